serial_subtractor: RTL

//  Bit-serial WIDTH-bit subtractor: computes diff = a - b, LSB first, one bit per clock.

---
 rtl/serial_subtractor_pkg.sv | 16 +
 rtl/serial_subtractor_fs.sv | 14 +
 rtl/serial_subtractor.sv | 115 +++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the helper that sizes the bit counter.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Counter width for a WIDTH-bit operand; never narrower than one bit.
  function automatic int cntW(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// Single-bit full-subtractor cell: d = a - b - borrow_in, with the borrow
// that the next more significant bit must absorb.
module full_subtractor_s (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic d,
  output logic borrow_out
);

  assign d          = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, one bit per
// clock through a single full-subtractor cell, with a start/busy/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int                CNT_W    = cntW(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   d_sr_q, d_sr_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;

  logic               cellD;
  logic               cellBorrow;

  full_subtractor_s u_cell (
    .a          (a_sr_q[0]),
    .b          (b_sr_q[0]),
    .borrow_in  (borrow_q),
    .d          (cellD),
    .borrow_out (cellBorrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      d_sr_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      d_sr_q   <= d_sr_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    d_sr_d   = d_sr_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_SHIFT;
        end
      end

      S_SHIFT: begin
        d_sr_d   = {cellD, d_sr_q[WIDTH-1:1]};
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        borrow_d = cellBorrow;
        // The counter parks on its last value rather than wrapping.
        if (cnt_q == CNT_LAST) begin
          diff_d  = {cellD, d_sr_q[WIDTH-1:1]};
          bout_d  = cellBorrow;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule
